tawas_au_sched: RTL
===================

# tawas_au_sched

Per-slice AU issue scheduler for the two-slice Tawas core. It buffers AU operations from the slice-0 and slice-1 decode paths. It sequences the mandatory immediate-prefix load (AU_IMM_VLD) ahead of each immediate-form op, and presents each op to the arithmetic unit only in a cycle whose SLICE matches the op's slice. It sits between the decoders and the AU and drives the AU's AU_OP_VLD/AU_OP/AU_IMM_VLD/AU_IMM inputs.

## Interface
- DEPTH, 2, entries per slice FIFO; power of two, at least 2.
- CLK  in  1  clock.
- RST  in  1  reset; asynchronous, active-high.
- SLICE  in  1  current slice. The same signal drives the AU; 0 means slice 0.
- S0_REQ_VLD / S1_REQ_VLD  in  1  per-slice request push strobe.
- S0_REQ_OP / S1_REQ_OP  in  15  AU op word; bit 14 is the immediate flag.
- S0_REQ_IMM / S1_REQ_IMM  in  28  immediate bits [31:4]; ignored when op bit 14 is 0.
- S0_REQ_RDY / S1_REQ_RDY  out  1  FIFO can accept a push this cycle.
- S0_FLUSH / S1_FLUSH  in  1  discard all pending work for that slice.
- S0_BUSY / S1_BUSY  out  1  FIFO non-empty or slice FSM not IDLE.
- AU_OP_VLD  out  1  op issue to the AU.
- AU_OP  out  15  op issued; 0 when AU_OP_VLD is 0.
- AU_IMM_VLD  out  1  immediate-hold load to the AU.
- AU_IMM  out  28  immediate value; 0 when AU_IMM_VLD is 0.

## Operation
- Each slice has its own FIFO of {op, imm}. A push happens when REQ_VLD and REQ_RDY are both 1.
- REQ_RDY = (count < DEPTH) && !RST.
- Each slice has its own FSM:
  - IDLE: FIFO empty.
  - IMM: the head entry needs an immediate load.
  - OP: the head entry is ready to issue.
- FSM transitions:
  - On entry to a new head with op[14]=1 → IMM; with op[14]=0 → OP.
  - IMM → OP after the IMM issue cycle.
  - OP → IMM, OP or IDLE according to the next head (rule above) after the op issues. The head pops on that edge.
- The outputs are combinational from registered FSM/FIFO state and SLICE. Only slice SLICE may drive the AU in a cycle:
  - IMM state: AU_IMM_VLD=1, AU_IMM = head imm.
  - OP state: AU_OP_VLD=1, AU_OP = head op.
- AU_IMM_VLD and AU_OP_VLD are never both 1 in the same cycle. The AU consumes its hold register in the op cycle, so the prefix must precede the op.
- FLUSH (per slice):
  - Empties the FIFO and returns the FSM to IDLE on the next edge.
  - Invalidates that slice's immediate cache.
  - Has priority over a simultaneous push, which is dropped, and over a simultaneous issue. An issue already driven combinationally in the flush cycle still reaches the AU; the pop is discarded.
- Slices are fully independent. Flushing one slice never disturbs the other.

## Timing
- Reset state: all outputs 0 (REQ_RDY 0 while RST is high), FIFOs empty, FSMs IDLE, caches invalid.
- Earliest issue: first cycle after the push edge with SLICE == the op's slice. Minimum latency is 1 cycle, maximum 2.
- Immediate op: IMM load in cycle t and op in cycle t+2 (the next same-slice cycle), so 2 slice turns per immediate op.
- Throughput is one AU action per cycle total, i.e. one per slice every 2 cycles.
- REQ_RDY reflects the registered count, so there is no same-cycle push-through at full. A pop frees its slot from the following cycle.
- Reset mid-operation abandons any pending IMM→OP pair. The AU hold content is then unknown, so the cache is invalid.

## Configuration
- TAWAS_AU_SCHED_IMM_CACHE_EN defined:
  - Each slice keeps {valid, last loaded imm}, set on every IMM issue.
  - A new head with op[14]=1 whose imm equals the valid cached value goes directly to OP and skips the load.
  - The cache is invalidated by reset and by flush.
- Not defined: every immediate op takes an IMM cycle, and no cache registers exist.

## Structure
- Package tawas_au_pkg holds:
  - op width 15 and immediate width 28;
  - immediate-flag bit index 14;
  - the slice FSM state enum {IDLE, IMM, OP}.
- One sub-module, tawas_au_sched_fifo (DEPTH, push/pop/flush, count, head), instantiated once per slice. The FSM, issue mux and cache live in the top.

## Test plan
- Push S0 op 0x0601 (no imm) in a SLICE=1 cycle → next cycle (SLICE=0): AU_OP_VLD=1, AU_OP=0x0601, AU_IMM_VLD=0; S0_BUSY drops after that edge.
- Push S1 op 0x4653 with imm 0xABCDEF0 → first SLICE=1 cycle: AU_IMM_VLD=1, AU_IMM=0xABCDEF0; two cycles later: AU_OP=0x4653.
- Push two S0 imm ops with identical imm 0x0000123 → with the macro: one IMM load, ops 2 cycles apart. Without it: IMM, OP, IMM, OP on consecutive slice-0 turns.
- DEPTH=2, push three S0 imm ops back-to-back → third push sees S0_REQ_RDY=0. RDY returns to 1 the cycle after the first op issues, and the third op is accepted then.
- Assert S0_FLUSH in the cycle after an S0 IMM issue → no AU_OP_VLD for slice 0 and S0_BUSY=0. A later op with the same imm is preceded by a fresh IMM load, even with the macro.
- Keep both FIFOs fed with non-imm ops → AU_OP_VLD=1 every cycle, AU_OP alternating between S0 and S1 ops in lockstep with SLICE. Assert RST mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/tawas_au_pkg.sv
// tawas_au_pkg: shared widths, FIFO entry layout and slice FSM states for the AU scheduler.
package tawas_au_pkg;
  localparam int OP_W = 15;
  localparam int IMM_W = 28;
  localparam int IMM_BIT = 14;
  typedef enum logic [1:0] {IDLE, IMM, OP} au_state_e;
  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [IMM_W-1:0] imm;
  } au_entry_t;
  function automatic logic needs_imm(au_entry_t e, logic cache_vld, logic [IMM_W-1:0] cache_imm);
    return e.op[IMM_BIT] && !(cache_vld && cache_imm == e.imm);
  endfunction
endpackage

// File: rtl/tawas_au_sched_if.sv
// tawas_au_sched_if: decoder-side request/flush signals and AU issue outputs of the scheduler.
interface tawas_au_sched_if;
  import tawas_au_pkg::*;
  logic SLICE;
  logic S0_REQ_VLD, S1_REQ_VLD, S0_REQ_RDY, S1_REQ_RDY;
  logic [OP_W-1:0] S0_REQ_OP, S1_REQ_OP;
  logic [IMM_W-1:0] S0_REQ_IMM, S1_REQ_IMM;
  logic S0_FLUSH, S1_FLUSH, S0_BUSY, S1_BUSY;
  logic AU_OP_VLD, AU_IMM_VLD;
  logic [OP_W-1:0] AU_OP;
  logic [IMM_W-1:0] AU_IMM;
  modport master (
    output SLICE, S0_REQ_VLD, S1_REQ_VLD, S0_REQ_OP, S1_REQ_OP, S0_REQ_IMM, S1_REQ_IMM, S0_FLUSH, S1_FLUSH,
    input S0_REQ_RDY, S1_REQ_RDY, S0_BUSY, S1_BUSY, AU_OP_VLD, AU_OP, AU_IMM_VLD, AU_IMM
  );
  modport slave (
    input SLICE, S0_REQ_VLD, S1_REQ_VLD, S0_REQ_OP, S1_REQ_OP, S0_REQ_IMM, S1_REQ_IMM, S0_FLUSH, S1_FLUSH,
    output S0_REQ_RDY, S1_REQ_RDY, S0_BUSY, S1_BUSY, AU_OP_VLD, AU_OP, AU_IMM_VLD, AU_IMM
  );
endinterface

// File: rtl/tawas_au_sched_fifo.sv
// tawas_au_sched_fifo: per-slice {op, imm} FIFO; flush beats push and pop, next_o peeks the entry behind the head.
module tawas_au_sched_fifo
  import tawas_au_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  au_entry_t              din_i,
  output logic [$clog2(DEPTH):0] count_o,
  output au_entry_t              head_o,
  output au_entry_t              next_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  au_entry_t mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q, rd_n;
  logic [CW-1:0] cnt_q;
  assign rd_n = rd_q + AW'(1);
  assign count_o = cnt_q;
  assign head_o = mem_q[rd_q];
  assign next_o = mem_q[rd_n];
  always_ff @(posedge CLK) if (push_i && !flush_i) mem_q[wr_q] <= din_i;
  always_ff @(posedge CLK or posedge RST)
    if (RST || flush_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i) rd_q <= rd_n;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
endmodule

// File: rtl/tawas_au_sched.sv
// tawas_au_sched: two-slice AU issue scheduler with immediate-prefix sequencing.
// Optional immediate cache enabled by TAWAS_AU_SCHED_IMM_CACHE_EN.
module tawas_au_sched
  import tawas_au_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic CLK,
  input logic RST,
  tawas_au_sched_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [1:0] req_vld, flush, rdy, busy, op_iss, imm_iss;
  logic [OP_W-1:0] req_op [2];
  logic [IMM_W-1:0] req_imm [2];
  au_entry_t heads [2];
  assign req_vld = {bus.S1_REQ_VLD, bus.S0_REQ_VLD};
  assign flush = {bus.S1_FLUSH, bus.S0_FLUSH};
  assign req_op[0] = bus.S0_REQ_OP;
  assign req_op[1] = bus.S1_REQ_OP;
  assign req_imm[0] = bus.S0_REQ_IMM;
  assign req_imm[1] = bus.S1_REQ_IMM;
  genvar s;
  for (s = 0; s < 2; s++) begin : g_sl
    logic my, push, deep;
    logic [CW-1:0] cnt;
    au_entry_t head, nxt, cand;
    logic cache_vld;
    logic [IMM_W-1:0] cache_imm;
    au_state_e state_q, state_d;
    assign my = bus.SLICE == (s == 1);
    assign push = req_vld[s] && rdy[s];
    assign op_iss[s] = state_q == OP && my;
    assign imm_iss[s] = state_q == IMM && my;
    assign deep = state_q == OP && cnt > CW'(1);
    // Head that becomes current after a pop, or the first push into an empty FIFO
    assign cand = deep ? nxt : {req_op[s], req_imm[s]};
    assign rdy[s] = cnt < CW'(DEPTH) && !RST;
    assign busy[s] = cnt != '0 || state_q != IDLE;
    assign heads[s] = head;
    always_comb
      state_d = flush[s] ? IDLE :
                imm_iss[s] ? OP :
                (state_q == IDLE || op_iss[s]) ?
                  ((deep || push) ? (needs_imm(cand, cache_vld, cache_imm) ? IMM : OP) : IDLE) :
                state_q;
    always_ff @(posedge CLK or posedge RST)
      if (RST) state_q <= IDLE;
      else state_q <= state_d;
`ifdef TAWAS_AU_SCHED_IMM_CACHE_EN
    always_ff @(posedge CLK or posedge RST)
      if (RST || flush[s]) begin
        cache_vld <= 1'b0;
        cache_imm <= '0;
      end else if (imm_iss[s]) begin
        cache_vld <= 1'b1;
        cache_imm <= head.imm;
      end
`else
    assign cache_vld = 1'b0;
    assign cache_imm = '0;
`endif
    tawas_au_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
      .CLK     (CLK),
      .RST     (RST),
      .push_i  (push),
      .pop_i   (op_iss[s]),
      .flush_i (flush[s]),
      .din_i   ({req_op[s], req_imm[s]}),
      .count_o (cnt),
      .head_o  (head),
      .next_o  (nxt)
    );
  end
  assign bus.S0_REQ_RDY = rdy[0];
  assign bus.S1_REQ_RDY = rdy[1];
  assign bus.S0_BUSY = busy[0];
  assign bus.S1_BUSY = busy[1];
  assign bus.AU_OP_VLD = |op_iss;
  assign bus.AU_IMM_VLD = |imm_iss;
  assign bus.AU_OP = op_iss[0] ? heads[0].op : op_iss[1] ? heads[1].op : '0;
  assign bus.AU_IMM = imm_iss[0] ? heads[0].imm : imm_iss[1] ? heads[1].imm : '0;
endmodule
